rv_decode_stage: RTL

//  Registered decode stage, generalised successor of the RV32I opcode decoder, for the RV32I/RV64I pipelines.

---
 rtl/rv_decode_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage: one output register plus a one-entry skid buffer.
// Optional illegal-encoding checks are enabled by defining DECODE_ILLEGAL_CHECK_EN.
module rv_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 5
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    input  logic [31:0]          instrIn,
    input  logic [XLEN-1:0]      pcIn,
    input  logic                 inValid,
    output logic                 inReady,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      pcOut,
    output logic [REG_COUNT-1:0] rs1,
    output logic [REG_COUNT-1:0] rs2,
    output logic [REG_COUNT-1:0] rd,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [XLEN-1:0]      imm,
    output logic [12:0]          opClass,
    output logic                 illegal
);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [REG_COUNT-1:0] rs1;
        logic [REG_COUNT-1:0] rs2;
        logic [REG_COUNT-1:0] rd;
        logic [2:0]           f3;
        logic [6:0]           f7;
        logic [XLEN-1:0]      imm;
        logic [12:0]          cls;
        logic                 ill;
    } bundle_t;

    bundle_t    dec;
    bundle_t    out_q, out_d, skid_q, skid_d;
    logic       out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic       accept;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       chk_ill;

    assign op = instrIn[6:2];
    assign f3 = instrIn[14:12];
    assign f7 = instrIn[31:25];

    always_comb begin
        dec     = '0;
        chk_ill = 1'b0;
        dec.pc  = pcIn;
        dec.rs1 = REG_COUNT'(instrIn[19:15]);
        dec.rs2 = REG_COUNT'(instrIn[24:20]);
        dec.rd  = REG_COUNT'(instrIn[11:7]);
        dec.f3  = f3;
        dec.f7  = f7;
        case (op)
            5'b00000: dec.cls[0]  = 1'b1;
            5'b01000: dec.cls[1]  = 1'b1;
            5'b00011: dec.cls[2]  = 1'b1;
            5'b01100: dec.cls[3]  = 1'b1;
            5'b00100: dec.cls[4]  = 1'b1;
            5'b01101: dec.cls[5]  = 1'b1;
            5'b00101: dec.cls[6]  = 1'b1;
            5'b11011: dec.cls[7]  = 1'b1;
            5'b11001: dec.cls[8]  = 1'b1;
            5'b11000: dec.cls[9]  = 1'b1;
            5'b11100: dec.cls[10] = 1'b1;
            5'b00110: dec.cls[11] = (XLEN == 64);
            5'b01110: dec.cls[12] = (XLEN == 64);
            default:  dec.cls     = '0;
        endcase
        // Immediate format follows the class; every format sign-extends from instr[31].
        if (dec.cls[0] | dec.cls[4] | dec.cls[11] | dec.cls[8] | dec.cls[10])
            dec.imm = XLEN'($signed(instrIn[31:20]));
        else if (dec.cls[1])
            dec.imm = XLEN'($signed({instrIn[31:25], instrIn[11:7]}));
        else if (dec.cls[9])
            dec.imm = XLEN'($signed({instrIn[31], instrIn[7], instrIn[30:25], instrIn[11:8], 1'b0}));
        else if (dec.cls[5] | dec.cls[6])
            dec.imm = XLEN'($signed({instrIn[31:12], 12'b0}));
        else if (dec.cls[7])
            dec.imm = XLEN'($signed({instrIn[31], instrIn[19:12], instrIn[20], instrIn[30:21], 1'b0}));
        else
            dec.imm = '0;
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (dec.cls[0])
            chk_ill = (XLEN == 64) ? (f3 == 3'b111)
                                   : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        if (dec.cls[1])
            chk_ill = (XLEN == 64) ? (f3 >= 3'b100) : (f3 >= 3'b011);
        if (dec.cls[9])
            chk_ill = (f3 == 3'b010 || f3 == 3'b011);
        if (dec.cls[8])
            chk_ill = (f3 != 3'b000);
        if (dec.cls[3])
            chk_ill = (f7 != 7'b0000000 && f7 != 7'b0100000)
                   || (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
        if (dec.cls[4] && f3[1:0] == 2'b01)
            chk_ill = (XLEN == 64) ? (instrIn[31:26] != 6'b000000 && instrIn[31:26] != 6'b010000)
                                   : (f7 != 7'b0000000 && f7 != 7'b0100000);
        if (dec.cls[10])
            chk_ill = (f3 == 3'b000 && instrIn != 32'h0000_0073 && instrIn != 32'h0010_0073)
                   || (f3 == 3'b100);
`endif
        dec.ill = (instrIn[1:0] != 2'b11) || (dec.cls == '0) || chk_ill;
    end

    assign inReady = ~skid_valid_q;
    assign accept  = inValid && !skid_valid_q;

    // Skid drains into the output register before new input; it can only fill while output stalls.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || outReady) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept)
                    out_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign outValid = out_valid_q;
    assign pcOut    = out_q.pc;
    assign rs1      = out_q.rs1;
    assign rs2      = out_q.rs2;
    assign rd       = out_q.rd;
    assign funct3   = out_q.f3;
    assign funct7   = out_q.f7;
    assign imm      = out_q.imm;
    assign opClass  = out_q.cls;
    assign illegal  = out_q.ill;

endmodule
